d5m_frame_gen: RTL and testbench

D5M_FRAME_GEN -- requirements
Module: d5m_frame_gen

---
 rtl/d5m_frame_gen.sv | 128 ++++++++++++
 tb/tb_d5m_frame_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/d5m_frame_gen.sv
// d5m_frame_gen: D5M-style frame/line timing generator with selectable test patterns.
// Ports: pixclk / ARESETN   sole clock, asynchronous active-low reset
//        enable             run request, sampled only in IDLE and at VBLANK exit
//        pattern_sel        test pattern, latched on entry to FRONT
//        ifval/ilval/idata  frame valid, line valid, pixel data (all registered)
//        xCord/yCord        current pixel column/row, 0 outside active lines
//        endOfFrame         one-cycle pulse in the first VBLANK cycle
//        frame_cnt          completed frames, wraps at 0xFFFF
//        busy               high whenever not IDLE
module d5m_frame_gen #(
    parameter int DATA_WIDTH  = 12,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 32,
    parameter int FRONT_PORCH = 8,
    parameter int H_BLANK     = 16,
    parameter int BACK_PORCH  = 8,
    parameter int V_BLANK     = 64
) (
    input  logic                  pixclk,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic                  ifval,
    output logic                  ilval,
    output logic [DATA_WIDTH-1:0] idata,
    output logic [15:0]           xCord,
    output logic [15:0]           yCord,
    output logic                  endOfFrame,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);
    localparam int M1 = FRONT_PORCH > H_BLANK ? FRONT_PORCH : H_BLANK;
    localparam int M2 = BACK_PORCH > V_BLANK ? BACK_PORCH : V_BLANK;
    localparam int MP = M1 > M2 ? M1 : M2;
    localparam int CW = MP > 1 ? $clog2(MP) : 1;
    localparam logic [15:0] XL = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] YL = 16'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, BACK, VBLANK} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           x_q, x_d, y_q, y_d, ycord_q, ycord_d, frame_cnt_q, frame_cnt_d;
    logic [1:0]            pat_q, pat_d;
    logic                  ifval_q, ifval_d, ilval_q, ilval_d, eof_q, eof_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0] idata_q, idata_d, pix;
    logic [11:0]           bayer;
    logic                  adv, start;
    int                    lin;

    function automatic logic is_last(input logic [CW-1:0] c, input int len);
        return int'(c) == len - 1;
    endfunction

    always_comb begin
        adv     = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) begin adv = 1'b1; state_d = FRONT; end
            FRONT:   if (is_last(cnt_q, FRONT_PORCH)) begin adv = 1'b1; state_d = LINE; end
            LINE:    if (x_q == XL) begin adv = 1'b1; state_d = (y_q == YL) ? BACK : HBLANK; end
            HBLANK:  if (is_last(cnt_q, H_BLANK)) begin adv = 1'b1; state_d = LINE; end
            BACK:    if (is_last(cnt_q, BACK_PORCH)) begin adv = 1'b1; state_d = VBLANK; end
            VBLANK:  if (is_last(cnt_q, V_BLANK)) begin adv = 1'b1; state_d = enable ? FRONT : IDLE; end
            default: begin adv = 1'b1; state_d = IDLE; end
        endcase
        // Zero-length phases are resolved in chain order so the skip costs no cycle.
        if (adv && state_d == HBLANK && H_BLANK == 0) state_d = LINE;
        if (adv && state_d == BACK && BACK_PORCH == 0) state_d = VBLANK;
        eof_d = adv && state_d == VBLANK;
        if (eof_d && V_BLANK == 0) state_d = enable ? FRONT : IDLE;
        start = adv && state_d == FRONT;
        if (start && FRONT_PORCH == 0) state_d = LINE;
        cnt_d       = adv ? '0 : cnt_q + CW'(1);
        x_d         = (state_q == LINE && state_d == LINE && !adv) ? x_q + 16'd1 : 16'd0;
        y_d         = start ? 16'd0 : (state_q == LINE && adv && y_q != YL) ? y_q + 16'd1 : y_q;
        pat_d       = start ? pattern_sel : pat_q;
        frame_cnt_d = frame_cnt_q + 16'(eof_d);
        bayer       = {y_d[0], x_d[0]} == 2'b01 ? 12'hF00 : {y_d[0], x_d[0]} == 2'b10 ? 12'h0F0 : 12'h800;
        lin         = int'(y_d) * IMG_WIDTH + int'(x_d);
        pix         = pat_d == 2'd0 ? DATA_WIDTH'(x_d) : pat_d == 2'd1 ? DATA_WIDTH'(bayer) :
                      pat_d == 2'd2 ? DATA_WIDTH'(lin) : DATA_WIDTH'(frame_cnt_q);
        ilval_d     = state_d == LINE;
        ifval_d     = state_d != IDLE && state_d != VBLANK;
        busy_d      = state_d != IDLE;
        idata_d     = ilval_d ? pix : '0;
        ycord_d     = ilval_d ? y_d : 16'd0;
    end

    always_ff @(posedge pixclk or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            ycord_q     <= '0;
            pat_q       <= '0;
            frame_cnt_q <= '0;
            ifval_q     <= 1'b0;
            ilval_q     <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            idata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ycord_q     <= ycord_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            ifval_q     <= ifval_d;
            ilval_q     <= ilval_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
            idata_q     <= idata_d;
        end
    end

    assign ifval      = ifval_q;
    assign ilval      = ilval_q;
    assign idata      = idata_q;
    assign xCord      = x_q;
    assign yCord      = ycord_q;
    assign endOfFrame = eof_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_d5m_frame_gen.sv
// tb_d5m_frame_gen: scoreboard bench for d5m_frame_gen with a small timing configuration.
module tb_d5m_frame_gen;
    logic        pixclk, ARESETN, enable;
    logic [1:0]  pattern_sel;
    logic        ifval, ilval, endOfFrame, busy;
    logic [11:0] idata;
    logic [15:0] xCord, yCord, frame_cnt;

    int vecs = 0;
    int miscompares = 0;
    logic [43:0] sb[$];
    localparam logic [11:0] BAYER [8] = '{12'h800, 12'hF00, 12'h800, 12'hF00,
                                          12'h0F0, 12'h800, 12'h0F0, 12'h800};

    d5m_frame_gen #(.DATA_WIDTH(12), .IMG_WIDTH(4), .IMG_HEIGHT(2), .FRONT_PORCH(2),
                    .H_BLANK(3), .BACK_PORCH(2), .V_BLANK(5)) dut (
        .pixclk(pixclk), .ARESETN(ARESETN), .enable(enable), .pattern_sel(pattern_sel),
        .ifval(ifval), .ilval(ilval), .idata(idata), .xCord(xCord), .yCord(yCord),
        .endOfFrame(endOfFrame), .frame_cnt(frame_cnt), .busy(busy)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int pat, input logic [15:0] fc);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                logic [11:0] d;
                d = pat == 0 ? 12'(x) : pat == 1 ? BAYER[y*4+x] : pat == 2 ? 12'(y*4+x) : fc[11:0];
                sb.push_back({16'(x), 16'(y), d});
            end
    endtask

    always @(negedge pixclk) begin
        if (ARESETN) begin
            if (ilval) begin
                if (sb.size() == 0) begin
                    vecs++;
                    miscompares++;
                    $display("FAIL pixel_unexpected got %h expected none", {xCord, yCord, idata});
                end else chk("pixel", {xCord, yCord, idata}, sb.pop_front());
            end else chk("blank_zero", {xCord, yCord, idata}, 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, eofs, ifany;
        logic [14:0] ilv;
        ARESETN = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
        #2 ARESETN = 1'b0;
        #21;
        chk("rst_ifval", ifval, 0);
        chk("rst_ilval", ilval, 0);
        chk("rst_idata", idata, 0);
        chk("rst_eof", endOfFrame, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge pixclk) ARESETN = 1'b1;
        repeat (3) @(negedge pixclk);
        chk("idle_busy", busy, 0);

        // enable dropped in 3rd LINE cycle: frame completes, then IDLE
        push_frame(0, 16'd0);
        enable = 1'b1;
        for (int i = 0; i < 100 && !(ilval && xCord == 16'd2); i++) @(negedge pixclk);
        chk("third_line_cycle", ilval && xCord == 16'd2, 1);
        enable = 1'b0;
        for (int i = 0; i < 100 && ifval; i++) @(negedge pixclk);
        chk("drop_fall", ifval, 0);
        chk("drop_eof", endOfFrame, 1);
        chk("drop_frame_cnt", frame_cnt, 1);
        eofs = 0; ifany = 0;
        repeat (10) begin
            @(negedge pixclk);
            eofs += int'(endOfFrame);
            ifany |= int'(ifval);
        end
        chk("drop_extra_eof", eofs, 0);
        chk("drop_no_restart", ifany, 0);
        chk("drop_busy", busy, 0);
        chk("drop_sb_empty", sb.size(), 0);

        // continuous run: timing and patterns 0, 1, 2, 3
        push_frame(0, 16'd0);
        enable = 1'b1;
        for (int i = 0; i < 100 && !ifval; i++) @(negedge pixclk);
        hi = 0; ilv = '0;
        while (ifval && hi < 40) begin
            ilv = {ilv[13:0], ilval};
            hi++;
            @(negedge pixclk);
        end
        chk("ifval_high", hi, 15);
        chk("ilval_shape", ilv, 15'b001111000111100);
        chk("eof_frame2", endOfFrame, 1);
        chk("frame_cnt_2", frame_cnt, 2);
        pattern_sel = 2'd1;
        push_frame(1, 16'd0);
        lo = 0;
        while (!ifval && lo < 40) begin
            lo++;
            @(negedge pixclk);
        end
        chk("ifval_low", lo, 5);
        for (int i = 0; i < 100 && ifval; i++) @(negedge pixclk);
        chk("frame3_cnt", frame_cnt, 3);
        pattern_sel = 2'd2;
        push_frame(2, 16'd0);
        for (int i = 0; i < 100 && !ilval; i++) @(negedge pixclk);
        pattern_sel = 2'd3;
        for (int i = 0; i < 100 && ifval; i++) @(negedge pixclk);
        chk("frame4_cnt", frame_cnt, 4);
        push_frame(3, 16'd4);

        // reset mid-line 1
        for (int i = 0; i < 100 && !(ilval && yCord == 16'd1 && xCord == 16'd1); i++) @(negedge pixclk);
        chk("line1_reached", ilval && yCord == 16'd1, 1);
        #1 ARESETN = 1'b0;
        #1;
        chk("async_ifval", ifval, 0);
        chk("async_ilval", ilval, 0);
        chk("async_frame_cnt", frame_cnt, 0);
        chk("async_eof", endOfFrame, 0);
        sb.delete();
        pattern_sel = 2'd0;
        push_frame(0, 16'd0);
        @(negedge pixclk) ARESETN = 1'b1;
        @(negedge pixclk);
        chk("front_after_release", ifval, 1);
        chk("front_ilval", ilval, 0);

        // frame_cnt wrap, then pattern 3 shows the wrapped count
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge pixclk);
        release dut.frame_cnt_q;
        chk("preload", frame_cnt, 16'hFFFF);
        for (int i = 0; i < 100 && ifval; i++) @(negedge pixclk);
        chk("wrap_eof", endOfFrame, 1);
        chk("wrap_cnt", frame_cnt, 0);
        pattern_sel = 2'd3;
        push_frame(3, 16'd0);
        for (int i = 0; i < 100 && !ifval; i++) @(negedge pixclk);
        for (int i = 0; i < 100 && ifval; i++) @(negedge pixclk);
        enable = 1'b0;
        repeat (8) @(negedge pixclk);
        chk("end_busy", busy, 0);
        chk("end_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
